// File: rtl/if_stage.sv
// if_stage: instruction fetch with credit-limited imem requests and an in-order response queue.
// Define IF_PERF_CNT_EN to add the fetch_count_o / bubble_count_o performance counters.
//
// state   | meaning
// S_IDLE  | first cycle after reset release, no requests
// S_FETCH | normal fetching, no stale responses in flight
// S_DRAIN | stale responses from before a redirect still in flight; new fetches continue
module if_stage #(
   parameter int                   WORD_SIZE  = 32,
   parameter int                   ADDR_SIZE  = 10,
   parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0,
   parameter int                   FIFO_DEPTH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 stall_i,
   input  logic                 redirect_i,
   input  logic [ADDR_SIZE-1:0] redirect_pc_i,
   output logic                 imem_req_o,
   output logic [ADDR_SIZE-1:0] imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [WORD_SIZE-1:0] imem_rdata_i,
   output logic [ADDR_SIZE-1:0] pc_out_o,
   output logic [WORD_SIZE-1:0] instr_out_o,
   output logic                 instr_valid_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]          fetch_count_o,
   output logic [31:0]          bubble_count_o
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   // Stale responses do not consume credit, so the discard count gets headroom beyond FIFO_DEPTH.
   localparam int DW = 8;
   localparam logic [WORD_SIZE-1:0] NOP   = WORD_SIZE'(32'h0000_0013);
   localparam logic [ADDR_SIZE-1:0] ALIGN = ~ADDR_SIZE'(3);
   localparam logic [CW:0]          DEPTH = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

   state_e               state_q, state_d;
   logic [ADDR_SIZE-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0]        outs_q, outs_d;
   logic [DW-1:0]        discard_q, discard_d;
   logic [PW:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0] fifo_pc_q    [FIFO_DEPTH];
   logic [WORD_SIZE-1:0] fifo_instr_q [FIFO_DEPTH];

   logic [CW-1:0] occ;
   logic [PW-1:0] rd_idx;
   logic          empty, rsp_drop, rsp_take, credit, req, issue, push, pop;

   always_comb begin
      occ       = wr_ptr_q - rd_ptr_q;
      rd_idx    = rd_ptr_q[PW-1:0];
      empty     = (occ == '0);
      rsp_drop  = imem_rvalid_i && (discard_q != '0);
      rsp_take  = imem_rvalid_i && (discard_q == '0) && (outs_q != '0);
      credit    = ({1'b0, outs_q} + {1'b0, occ}) < DEPTH;
      req       = (state_q != S_IDLE) && !redirect_i && credit;
      issue     = req && imem_gnt_i;
      push      = rsp_take && !redirect_i;
      pop       = !empty && !stall_i && !redirect_i;
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      outs_d    = outs_q;
      discard_d = discard_q - DW'(rsp_drop);
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      if (redirect_i) begin
         // A same-cycle live response belongs to the old stream: drop it instead of discarding later.
         pc_d      = redirect_pc_i & ALIGN;
         resp_pc_d = redirect_pc_i & ALIGN;
         discard_d = discard_q - DW'(rsp_drop) + DW'(outs_q) - DW'(rsp_take);
         outs_d    = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
      end else begin
         if (issue) pc_d = pc_q + ADDR_SIZE'(4);
         if (push) begin
            resp_pc_d = resp_pc_q + ADDR_SIZE'(4);
            wr_ptr_d  = wr_ptr_q + (PW+1)'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
         outs_d = outs_q + CW'(issue) - CW'(rsp_take);
      end
      state_d = (discard_d != '0) ? S_DRAIN : S_FETCH;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC & ALIGN;
         outs_q    <= '0;
         discard_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         outs_q    <= outs_d;
         discard_q <= discard_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q[PW-1:0]]    <= resp_pc_q;
         fifo_instr_q[wr_ptr_q[PW-1:0]] <= imem_rdata_i;
      end
   end

   assign imem_req_o    = req;
   assign imem_addr_o   = pc_q & ALIGN;
   assign instr_valid_o = !empty;
   assign pc_out_o      = empty ? '0 : fifo_pc_q[rd_idx];
   assign instr_out_o   = empty ? NOP : fifo_instr_q[rd_idx];

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (!empty && !stall_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if ((state_q != S_IDLE) && empty && !stall_i) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign fetch_count_o  = fetch_cnt_q;
   assign bubble_count_o = bubble_cnt_q;
`endif

   a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(imem_rvalid_i && (outs_q == '0) && (discard_q == '0)));

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a queue-based fetch model, plus directed literal checks.
module tb_if_stage;
   localparam int AW = 10;
   localparam int WW = 32;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n, stall, redirect, gnt, rvalid, req, valid;
   logic [AW-1:0] rpc, addr, pc_o;
   logic [WW-1:0] rdata, instr;
`ifdef IF_PERF_CNT_EN
   logic [31:0]   fcnt, bcnt;
`endif

   always #5 clk = ~clk;

   if_stage #(.WORD_SIZE(WW), .ADDR_SIZE(AW), .RESET_PC(10'h000), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(rpc),
      .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
      .imem_rdata_i(rdata), .pc_out_o(pc_o), .instr_out_o(instr), .instr_valid_o(valid)
`ifdef IF_PERF_CNT_EN
      , .fetch_count_o(fcnt), .bubble_count_o(bcnt)
`endif
   );

   typedef struct { logic [AW-1:0] pc; logic [WW-1:0] instr; } fent_t;
   typedef struct { int addr; int ready; bit stale; } pend_t;

   fent_t fq[$];      // instructions ready for ID, oldest first
   pend_t pend[$];    // requests accepted by memory, in order
   int    m_pc, cyc, lat_v, fetch_m, bubble_m;
   bit    m_started;
   int    checks = 0;
   int    errors = 0;

   function automatic logic [WW-1:0] mem_word(input int a);
      return (32'(a) * 32'h0001_0001) ^ 32'hC0DE_0000;
   endfunction

   function automatic bit exp_req();
      int live = 0;
      foreach (pend[i]) if (!pend[i].stale) live++;
      return m_started && !redirect && ((live + fq.size()) < DEPTH);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stall = 1'b0; redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; rpc = '0;
      fq.delete(); pend.delete();
      m_pc = 0; m_started = 1'b0; cyc = 0; fetch_m = 0; bubble_m = 0;
      #1;
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_addr", 32'(addr), 32'h0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_pc_out", 32'(pc_o), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Memory side of the cycle: present the in-order response whose latency has elapsed.
   task automatic drive();
      rvalid = (pend.size() > 0) && (pend[0].ready <= cyc);
      rdata  = rvalid ? mem_word(pend[0].addr) : '0;
      @(negedge clk);
   endtask

   task automatic step();
      bit    er;
      pend_t r;
      int    rdy;
      er = exp_req();
      chk("imem_req", 32'(req), 32'(er));
      chk("imem_addr", 32'(addr), 32'(m_pc));
      chk("instr_valid", 32'(valid), 32'(fq.size() > 0));
      chk("pc_out", 32'(pc_o), (fq.size() > 0) ? 32'(fq[0].pc) : 32'h0);
      chk("instr_out", instr, (fq.size() > 0) ? fq[0].instr : 32'h0000_0013);
`ifdef IF_PERF_CNT_EN
      chk("fetch_count", fcnt, 32'(fetch_m));
      chk("bubble_count", bcnt, 32'(bubble_m));
`endif
      if (fq.size() > 0 && !stall) fetch_m++;
      if (m_started && fq.size() == 0 && !stall) bubble_m++;
      @(posedge clk);
      if (rvalid) r = pend.pop_front();
      if (redirect) begin
         fq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         m_pc = int'(rpc) & 'h3FC;
      end else begin
         if (fq.size() > 0 && !stall) void'(fq.pop_front());
         if (rvalid && !r.stale) fq.push_back('{AW'(r.addr), mem_word(r.addr)});
         if (er && gnt) begin
            rdy = cyc + lat_v;
            if (pend.size() > 0 && pend[$].ready >= rdy) rdy = pend[$].ready + 1;
            pend.push_back('{m_pc, rdy, 1'b0});
            m_pc = (m_pc + 4) % (1 << AW);
         end
      end
      m_started = 1'b1;
      cyc++;
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "tb_if_stage timeout");
   end

   initial begin
      bit          seen;
      int          ng;
      logic [31:0] got [3];

      lat_v = 1;
      do_reset();

      // Back-to-back fetch with latency 1, then stall with a full queue and release.
      gnt = 1'b1;
      for (int k = 0; k < 12; k++) begin
         stall = (k >= 5 && k <= 9);
         drive();
         case (k)
            0: chk("t1_req_idle", 32'(req), 32'd0);
            1: begin chk("t1_req1", 32'(req), 32'd1); chk("t1_addr1", 32'(addr), 32'h0); end
            2: chk("t1_addr2", 32'(addr), 32'h4);
            3: begin
               chk("t1_req3", 32'(req), 32'd0);
               chk("t1_pc3", 32'(pc_o), 32'h0);
               chk("t1_instr3", instr, mem_word(0));
            end
            4: begin chk("t1_addr4", 32'(addr), 32'h8); chk("t1_pc4", 32'(pc_o), 32'h4); end
            7, 8, 9: begin
               chk("t2_pc_hold", 32'(pc_o), 32'h8);
               chk("t2_instr_hold", instr, mem_word(8));
               chk("t2_req_off", 32'(req), 32'd0);
            end
            11: begin
               chk("t2_pc_next", 32'(pc_o), 32'hC);
               chk("t2_addr_next", 32'(addr), 32'h10);
            end
            default: ;
         endcase
         step();
      end

      // Redirect to 0x10, latency 3, then redirect away with both requests in flight.
      stall = 1'b0; lat_v = 3; redirect = 1'b1; rpc = 10'h010;
      drive(); step();
      redirect = 1'b0;
      drive(); chk("t3_addr10", 32'(addr), 32'h10); step();
      drive(); chk("t3_addr14", 32'(addr), 32'h14); step();
      redirect = 1'b1; rpc = 10'h100;
      drive(); step();
      redirect = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         drive();
         if (valid && (pc_o == 10'h010 || pc_o == 10'h014))
            chk("t3_stale_seen", 32'(pc_o), 32'h100);
         if (valid && !seen) begin
            seen = 1'b1;
            chk("t3_first_pc", 32'(pc_o), 32'h100);
         end
         step();
      end
      chk("t3_valid_within_bound", 32'(seen), 32'd1);

      // Redirect under stall to an unaligned target, then withhold grant.
      redirect = 1'b1; stall = 1'b1; rpc = 10'h203; gnt = 1'b0;
      drive(); step();
      redirect = 1'b0; stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive();
         chk("t5_addr_hold", 32'(addr), 32'h200);
         chk("t5_req_hold", 32'(req), 32'd1);
         chk("t5_valid_off", 32'(valid), 32'd0);
         step();
      end

      // Wrap at the top of the address space, then reset mid-stream.
      gnt = 1'b1; lat_v = 1; redirect = 1'b1; rpc = 10'h3F8;
      drive(); step();
      redirect = 1'b0;
      ng = 0;
      foreach (got[i]) got[i] = 32'hFFFF_FFFF;
      for (int i = 0; i < 10; i++) begin
         drive();
         if (req && gnt && ng < 3) begin
            got[ng] = 32'(addr);
            ng++;
         end
         step();
      end
      chk("t6_addr0", got[0], 32'h3F8);
      chk("t6_addr1", got[1], 32'h3FC);
      chk("t6_addr2", got[2], 32'h000);
      drive();
      do_reset();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         stall    = ($urandom_range(0, 99) < 25);
         redirect = ($urandom_range(0, 99) < 6);
         rpc      = AW'($urandom);
         gnt      = ($urandom_range(0, 99) < 75);
         lat_v    = $urandom_range(1, 4);
         drive();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
